d_cache_data_sequencer: RTL and testbench
=========================================

D_CACHE_DATA_SEQUENCER -- requirements
Module: d_cache_data_sequencer

Interface
REQ-001 SHALL have parameter BEAT_BITS, default 3, log2 of beats per cache line (8 beats of 64 bits = 64-byte line).
REQ-002 SHALL have parameter ADDR_W, default 13, width of the data-array byte address.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req_valid/cpu_req_ready  input/output  1/1  CPU single-beat request handshake.
REQ-006 cpu_req_addr, cpu_req_write, cpu_req_wdata, cpu_req_wmask  input  ADDR_W/1/64/8  CPU request fields.
REQ-007 cpu_resp_valid, cpu_resp_data  output  1/64  CPU read response.
REQ-008 refill_start, refill_line_addr  input  1/(ADDR_W-BEAT_BITS-3)  begin refill of the line at this line address.
REQ-009 refill_valid/refill_ready, refill_data  input/output, input  1/1, 64  refill beat stream.
REQ-010 wb_start, wb_line_addr  input  1/(ADDR_W-BEAT_BITS-3)  begin writeback read-out of the line at this line address.
REQ-011 wb_valid/wb_ready, wb_data, wb_last  output/input, output, output  1/1, 64, 1  writeback beat stream.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 io_req_valid, io_req_bits_addr, io_req_bits_write, io_req_bits_wdata, io_req_bits_wmask, io_req_bits_way_en  output  1/ADDR_W/1/64/8/1  data-array request; io_resp_0  input  64  array read data, valid one cycle after read issue.

Function
REQ-014 SHALL implement states IDLE, REFILL, WB_READ, WB_DRAIN.
REQ-015 IDLE: wb_start -> WB_READ; else refill_start -> REFILL; start pulses in non-IDLE states SHALL be ignored; the captured line address is held for the full burst.
REQ-016 IDLE with no start pulse: cpu_req_ready=1; an accepted CPU request SHALL drive io_req_valid=1 with its address, write, wdata, wmask in the same cycle (combinational pass-through).
REQ-017 An accepted CPU read SHALL assert cpu_resp_valid exactly one cycle later with cpu_resp_data=io_resp_0; writes produce no response.
REQ-018 cpu_req_ready SHALL be 0 in any cycle where a start pulse is taken and in every non-IDLE state.
REQ-019 REFILL: refill_ready=1; each refill_valid beat SHALL issue an array write, addr={line_addr, beat_cnt, 3'b000}, wmask=8'hFF, wdata=refill_data; beat_cnt increments per accepted beat.
REQ-020 REFILL SHALL return to IDLE in the cycle after beat 2^BEAT_BITS-1 is written; refill_ready=0 outside REFILL.
REQ-021 WB_READ: issues array reads at addr={line_addr, rd_cnt, 3'b000}, io_req_bits_write=0, only while (fifo occupancy + reads in flight) < 2.
REQ-022 Read data SHALL be captured one cycle after issue into a 2-entry FIFO that drives wb_valid/wb_data; a beat pops when wb_valid&wb_ready.
REQ-023 After the last read issues, WB_READ -> WB_DRAIN; WB_DRAIN -> IDLE when the final beat (wb_last=1) pops; wb_last SHALL be 1 only on beat 2^BEAT_BITS-1.
REQ-024 wb_data SHALL remain stable while wb_valid=1 and wb_ready=0; no beat lost or duplicated under arbitrary backpressure.
REQ-025 io_req_bits_way_en SHALL be constant 1; io_req_valid=0 when no access is issued; beat counters wrap to 0 at burst end.
REQ-026 Simultaneous wb_start and refill_start in IDLE: writeback wins; refill_start is dropped (requester re-asserts).

Reset
REQ-027 While reset=1: state=IDLE, counters=0, FIFO empty, read in flight cleared, and cpu_resp_valid, wb_valid, wb_last, refill_ready, io_req_valid, busy SHALL be 0 in the following cycle.
REQ-028 Reset mid-burst SHALL abort the burst with no further array access; the partially written line is not restored.

Verification
REQ-029 CPU write addr 0x0040 wdata 0x1122334455667788 wmask 0x0F, then read 0x0040 -> cpu_resp_valid one cycle after read accept, data low 32 bits 0x55667788.
REQ-030 Refill line 5 with beats 0..7 = k*0x0101010101010101 with random refill_valid gaps -> 8 writes at 0x140..0x178, return to IDLE, busy falls.
REQ-031 Writeback line 5 with wb_ready toggling 1-0-0-1 -> 8 beats in order matching REQ-030 data, wb_last on the 8th only, array never read while FIFO+inflight=2.
REQ-032 wb_start and refill_start in same cycle plus pending CPU request -> writeback runs, cpu_req_ready=0 until IDLE, refill never starts.
REQ-033 Reset asserted after refill beat 3 -> next cycle IDLE, refill_ready=0, io_req_valid=0; new refill then starts at beat 0.

Source files
------------

// File: rtl/d_cache_data_sequencer.sv
// Sequences the D-cache data array between single-beat CPU accesses, line refills from
// the refill stream, and line read-out into a 2-entry writeback FIFO.
module d_cache_data_sequencer #(
    parameter int unsigned BEAT_BITS = 3,
    parameter int unsigned ADDR_W    = 13
) (
    input  logic                            clk,
    input  logic                            reset,

    input  logic                            cpu_req_valid,
    output logic                            cpu_req_ready,
    input  logic [ADDR_W-1:0]               cpu_req_addr,
    input  logic                            cpu_req_write,
    input  logic [63:0]                     cpu_req_wdata,
    input  logic [7:0]                      cpu_req_wmask,
    output logic                            cpu_resp_valid,
    output logic [63:0]                     cpu_resp_data,

    input  logic                            refill_start,
    input  logic [ADDR_W-BEAT_BITS-4:0]     refill_line_addr,
    input  logic                            refill_valid,
    output logic                            refill_ready,
    input  logic [63:0]                     refill_data,

    input  logic                            wb_start,
    input  logic [ADDR_W-BEAT_BITS-4:0]     wb_line_addr,
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [63:0]                     wb_data,
    output logic                            wb_last,

    output logic                            busy,

    output logic                            io_req_valid,
    output logic [ADDR_W-1:0]               io_req_bits_addr,
    output logic                            io_req_bits_write,
    output logic [63:0]                     io_req_bits_wdata,
    output logic [7:0]                      io_req_bits_wmask,
    output logic                            io_req_bits_way_en,
    input  logic [63:0]                     io_resp_0
);

    localparam int unsigned LINE_W = ADDR_W - BEAT_BITS - 3;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = '1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REFILL   = 2'd1;
    localparam logic [1:0] WB_READ  = 2'd2;
    localparam logic [1:0] WB_DRAIN = 2'd3;

    logic [1:0]           stateQ, stateD;
    logic [LINE_W-1:0]    lineAddrQ;
    logic [BEAT_BITS-1:0] beatCntQ;
    logic [BEAT_BITS-1:0] rdCntQ;
    logic [BEAT_BITS-1:0] popCntQ;
    logic                 inflightQ;
    logic                 respPendingQ;
    logic [63:0]          fifoMem [2];
    logic                 wrPtrQ, rdPtrQ;
    logic [1:0]           fifoCntQ;

    logic                 idle;
    logic                 cpuFire;
    logic                 refillFire;
    logic                 wbIssue;
    logic                 wbPop;
    logic [1:0]           outstanding;

    assign idle          = (stateQ == IDLE);
    assign busy          = !idle;
    assign cpu_req_ready = !reset && idle && !wb_start && !refill_start;
    assign cpuFire       = cpu_req_valid && cpu_req_ready;
    assign refill_ready  = !reset && (stateQ == REFILL);
    assign refillFire    = refill_valid && refill_ready;

    // Throttle reads so buffered plus in-flight beats never exceed the FIFO depth.
    assign outstanding   = fifoCntQ + {1'b0, inflightQ};
    assign wbIssue       = !reset && (stateQ == WB_READ) && (outstanding < 2'd2);

    assign wb_valid      = !reset && (fifoCntQ != 2'd0);
    assign wb_data       = fifoMem[rdPtrQ];
    assign wb_last       = wb_valid && (popCntQ == LAST_BEAT);
    assign wbPop         = wb_valid && wb_ready;

    assign cpu_resp_valid     = respPendingQ;
    assign cpu_resp_data      = io_resp_0;
    assign io_req_bits_way_en = 1'b1;

    always_comb begin
        io_req_valid      = 1'b0;
        io_req_bits_addr  = '0;
        io_req_bits_write = 1'b0;
        io_req_bits_wdata = '0;
        io_req_bits_wmask = '0;
        if (cpuFire) begin
            io_req_valid      = 1'b1;
            io_req_bits_addr  = cpu_req_addr;
            io_req_bits_write = cpu_req_write;
            io_req_bits_wdata = cpu_req_wdata;
            io_req_bits_wmask = cpu_req_wmask;
        end else if (refillFire) begin
            io_req_valid      = 1'b1;
            io_req_bits_addr  = {lineAddrQ, beatCntQ, 3'b000};
            io_req_bits_write = 1'b1;
            io_req_bits_wdata = refill_data;
            io_req_bits_wmask = 8'hFF;
        end else if (wbIssue) begin
            io_req_valid      = 1'b1;
            io_req_bits_addr  = {lineAddrQ, rdCntQ, 3'b000};
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE: begin
                if (wb_start) begin
                    stateD = WB_READ;
                end else if (refill_start) begin
                    stateD = REFILL;
                end
            end
            REFILL: begin
                if (refillFire && (beatCntQ == LAST_BEAT)) begin
                    stateD = IDLE;
                end
            end
            WB_READ: begin
                if (wbIssue && (rdCntQ == LAST_BEAT)) begin
                    stateD = WB_DRAIN;
                end
            end
            WB_DRAIN: begin
                if (wbPop && wb_last) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ       <= IDLE;
            lineAddrQ    <= '0;
            beatCntQ     <= '0;
            rdCntQ       <= '0;
            popCntQ      <= '0;
            inflightQ    <= 1'b0;
            respPendingQ <= 1'b0;
            wrPtrQ       <= 1'b0;
            rdPtrQ       <= 1'b0;
            fifoCntQ     <= 2'd0;
        end else begin
            stateQ       <= stateD;
            inflightQ    <= wbIssue;
            respPendingQ <= cpuFire && !cpu_req_write;
            if (idle) begin
                if (wb_start) begin
                    lineAddrQ <= wb_line_addr;
                end else if (refill_start) begin
                    lineAddrQ <= refill_line_addr;
                end
            end
            if (refillFire) begin
                beatCntQ <= beatCntQ + 1'b1;
            end
            if (wbIssue) begin
                rdCntQ <= rdCntQ + 1'b1;
            end
            if (wbPop) begin
                popCntQ <= popCntQ + 1'b1;
                rdPtrQ  <= !rdPtrQ;
            end
            // Read data arrives the cycle after issue, which is when inflightQ is set.
            if (inflightQ) begin
                wrPtrQ <= !wrPtrQ;
            end
            if (inflightQ && !wbPop) begin
                fifoCntQ <= fifoCntQ + 2'd1;
            end else if (!inflightQ && wbPop) begin
                fifoCntQ <= fifoCntQ - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (inflightQ) begin
            fifoMem[wrPtrQ] <= io_resp_0;
        end
    end

endmodule

// File: tb/tb_d_cache_data_sequencer.sv
// Self-checking bench: a behavioural data array plus an intent-level reference memory that
// predicts CPU read data, refill write addresses and writeback beat order.
module tb_d_cache_data_sequencer;

    localparam int AW = 13;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_write;
    logic [12:0] cpu_req_addr;
    logic [63:0] cpu_req_wdata;
    logic [7:0]  cpu_req_wmask;
    logic        cpu_resp_valid;
    logic [63:0] cpu_resp_data;
    logic        refill_start, refill_valid, refill_ready;
    logic [6:0]  refill_line_addr;
    logic [63:0] refill_data;
    logic        wb_start, wb_valid, wb_ready, wb_last;
    logic [6:0]  wb_line_addr;
    logic [63:0] wb_data;
    logic        busy;
    logic        io_req_valid, io_req_bits_write, io_req_bits_way_en;
    logic [12:0] io_req_bits_addr;
    logic [63:0] io_req_bits_wdata;
    logic [7:0]  io_req_bits_wmask;
    logic [63:0] io_resp_0;

    logic [63:0] arrMem [1024];
    logic [63:0] refMem [1024];
    logic [63:0] beats [8];

    int nCmp = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    d_cache_data_sequencer #(.BEAT_BITS(3), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_write(cpu_req_write),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_wmask(cpu_req_wmask),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
        .refill_start(refill_start), .refill_line_addr(refill_line_addr),
        .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_data(refill_data),
        .wb_start(wb_start), .wb_line_addr(wb_line_addr), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_data(wb_data), .wb_last(wb_last),
        .busy(busy),
        .io_req_valid(io_req_valid), .io_req_bits_addr(io_req_bits_addr),
        .io_req_bits_write(io_req_bits_write), .io_req_bits_wdata(io_req_bits_wdata),
        .io_req_bits_wmask(io_req_bits_wmask), .io_req_bits_way_en(io_req_bits_way_en),
        .io_resp_0(io_resp_0)
    );

    // Data array model: byte-masked writes, registered read data one cycle after issue.
    always @(posedge clk) begin
        if (io_req_valid) begin
            if (io_req_bits_write) begin
                for (int b = 0; b < 8; b++) begin
                    if (io_req_bits_wmask[b]) begin
                        arrMem[io_req_bits_addr[12:3]][8*b +: 8] <= io_req_bits_wdata[8*b +: 8];
                    end
                end
            end else begin
                io_resp_0 <= arrMem[io_req_bits_addr[12:3]];
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        nCmp++;
        if ({busy, refill_ready, wb_valid, wb_last, io_req_valid, cpu_resp_valid} !== 6'b0) begin
            nErr++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {busy, refill_ready, wb_valid, wb_last, io_req_valid, cpu_resp_valid});
        end
        nCmp++;
        if (cpu_req_ready !== 1'b1) begin
            nErr++;
            $display("FAIL reset_ready: got %b expected 1", cpu_req_ready);
        end
    endtask

    task automatic test_cpu_basic();
        @(posedge clk); #1;
        cpu_req_valid = 1'b1; cpu_req_write = 1'b1; cpu_req_addr = 13'h040;
        cpu_req_wdata = 64'h1122334455667788; cpu_req_wmask = 8'h0F;
        @(negedge clk);
        nCmp++;
        if ({cpu_req_ready, io_req_valid, io_req_bits_write, io_req_bits_addr, io_req_bits_wdata,
             io_req_bits_wmask, io_req_bits_way_en} !==
            {1'b1, 1'b1, 1'b1, 13'h040, 64'h1122334455667788, 8'h0F, 1'b1}) begin
            nErr++;
            $display("FAIL cpu_write_pass: got addr %h data %h mask %h v%b w%b expected 040/1122334455667788/0f",
                     io_req_bits_addr, io_req_bits_wdata, io_req_bits_wmask, io_req_valid,
                     io_req_bits_write);
        end
        refMem[8][31:0] = 32'h55667788;
        @(posedge clk); #1;
        cpu_req_write = 1'b0;
        @(negedge clk);
        nCmp++;
        if ({cpu_resp_valid, io_req_valid, io_req_bits_write, io_req_bits_addr} !==
            {1'b0, 1'b1, 1'b0, 13'h040}) begin
            nErr++;
            $display("FAIL cpu_read_issue: got resp %b v%b w%b addr %h expected 0 1 0 040",
                     cpu_resp_valid, io_req_valid, io_req_bits_write, io_req_bits_addr);
        end
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        @(negedge clk);
        nCmp++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_data[31:0] !== 32'h55667788) begin
            nErr++;
            $display("FAIL cpu_read_resp: got v%b %h expected v1 low 55667788",
                     cpu_resp_valid, cpu_resp_data);
        end
        @(negedge clk);
        nCmp++;
        if (cpu_resp_valid !== 1'b0) begin
            nErr++;
            $display("FAIL cpu_resp_once: got %b expected 0", cpu_resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit prevRead = 1'b0;
        logic [63:0] prevExp = '0;
        logic [9:0] idx;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            cpu_req_valid = ($urandom % 4) != 0;
            cpu_req_write = ($urandom % 2) != 0;
            cpu_req_addr  = 13'($urandom);
            cpu_req_wdata = {$urandom, $urandom};
            cpu_req_wmask = 8'($urandom);
            @(negedge clk);
            nCmp++;
            if (cpu_resp_valid !== prevRead || (prevRead && cpu_resp_data !== prevExp)) begin
                nErr++;
                $display("FAIL b2b_resp op %0d: got v%b %h expected v%b %h",
                         i, cpu_resp_valid, cpu_resp_data, prevRead, prevExp);
            end
            nCmp++;
            if (io_req_valid !== cpu_req_valid ||
                (cpu_req_valid && io_req_bits_addr !== cpu_req_addr)) begin
                nErr++;
                $display("FAIL b2b_issue op %0d: got v%b addr %h expected v%b addr %h",
                         i, io_req_valid, io_req_bits_addr, cpu_req_valid, cpu_req_addr);
            end
            idx = cpu_req_addr[12:3];
            prevRead = cpu_req_valid && !cpu_req_write;
            if (prevRead) prevExp = refMem[idx];
            if (cpu_req_valid && cpu_req_write) begin
                for (int b = 0; b < 8; b++) begin
                    if (cpu_req_wmask[b]) refMem[idx][8*b +: 8] = cpu_req_wdata[8*b +: 8];
                end
            end
        end
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        @(negedge clk);
        nCmp++;
        if (cpu_resp_valid !== prevRead || (prevRead && cpu_resp_data !== prevExp)) begin
            nErr++;
            $display("FAIL b2b_last_resp: got v%b %h expected v%b %h",
                     cpu_resp_valid, cpu_resp_data, prevRead, prevExp);
        end
    endtask

    task automatic test_refill(input logic [6:0] line, input bit gaps);
        int k = 0;
        int guard = 0;
        @(posedge clk); #1;
        refill_start = 1'b1; refill_line_addr = line;
        cpu_req_valid = 1'b1; cpu_req_write = 1'b1;
        @(negedge clk);
        nCmp++;
        if (cpu_req_ready !== 1'b0 || io_req_valid !== 1'b0) begin
            nErr++;
            $display("FAIL refill_start_blocks_cpu: got ready %b io %b expected 0 0",
                     cpu_req_ready, io_req_valid);
        end
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        while (k < 8 && guard < 200) begin
            refill_valid = gaps ? ($urandom % 3 != 0) : 1'b1;
            refill_data = beats[k];
            refill_start = ($urandom % 4) == 0;
            refill_line_addr = 7'($urandom);
            @(negedge clk);
            guard++;
            nCmp++;
            if ({busy, refill_ready, cpu_req_ready} !== 3'b110) begin
                nErr++;
                $display("FAIL refill_status: got %b expected 110",
                         {busy, refill_ready, cpu_req_ready});
            end
            nCmp++;
            if (refill_valid) begin
                if ({io_req_valid, io_req_bits_write, io_req_bits_addr, io_req_bits_wdata,
                     io_req_bits_wmask, io_req_bits_way_en} !==
                    {1'b1, 1'b1, line, k[2:0], 3'b000, beats[k], 8'hFF, 1'b1}) begin
                    nErr++;
                    $display("FAIL refill_write beat %0d: got v%b w%b addr %h data %h mask %h expected addr %h data %h",
                             k, io_req_valid, io_req_bits_write, io_req_bits_addr,
                             io_req_bits_wdata, io_req_bits_wmask, {line, k[2:0], 3'b000},
                             beats[k]);
                end
                refMem[{line, k[2:0]}] = beats[k];
                k++;
            end else if (io_req_valid !== 1'b0) begin
                nErr++;
                $display("FAIL refill_idle_gap: got io_req_valid %b expected 0", io_req_valid);
            end
            @(posedge clk); #1;
        end
        refill_valid = 1'b0; refill_start = 1'b0;
        nCmp++;
        if (k != 8) begin
            nErr++;
            $display("FAIL refill_timeout: got %0d beats expected 8", k);
        end
        @(negedge clk);
        nCmp++;
        if ({busy, refill_ready, io_req_valid, cpu_req_ready} !== 4'b0001) begin
            nErr++;
            $display("FAIL refill_done: got %b expected 0001",
                     {busy, refill_ready, io_req_valid, cpu_req_ready});
        end
    endtask

    task automatic test_writeback(input logic [6:0] line, input bit randReady, input bit both);
        int issued = 0;
        int popped = 0;
        int guard = 0;
        bit holdValid = 1'b0;
        logic [63:0] holdData = '0;
        @(posedge clk); #1;
        wb_start = 1'b1; wb_line_addr = line;
        cpu_req_valid = both; cpu_req_write = 1'b0; cpu_req_addr = '0;
        if (both) begin
            refill_start = 1'b1; refill_line_addr = 7'(line + 1);
        end
        @(negedge clk);
        nCmp++;
        if (cpu_req_ready !== 1'b0 || io_req_valid !== 1'b0) begin
            nErr++;
            $display("FAIL wb_start_blocks_cpu: got ready %b io %b expected 0 0",
                     cpu_req_ready, io_req_valid);
        end
        @(posedge clk); #1;
        wb_start = 1'b0; refill_start = 1'b0;
        while (popped < 8 && guard < 300) begin
            wb_ready = randReady ? (($urandom % 2) != 0) : ((guard % 4) == 0 || (guard % 4) == 3);
            refill_start = ($urandom % 4) == 0;
            @(negedge clk);
            guard++;
            nCmp++;
            if ({busy, cpu_req_ready, refill_ready} !== 3'b100) begin
                nErr++;
                $display("FAIL wb_status: got %b expected 100",
                         {busy, cpu_req_ready, refill_ready});
            end
            if (holdValid) begin
                nCmp++;
                if (wb_valid !== 1'b1 || wb_data !== holdData) begin
                    nErr++;
                    $display("FAIL wb_stall_stable: got v%b %h expected v1 %h",
                             wb_valid, wb_data, holdData);
                end
            end
            if (io_req_valid) begin
                nCmp++;
                if (io_req_bits_write !== 1'b0 || io_req_bits_way_en !== 1'b1 ||
                    io_req_bits_addr !== {line, issued[2:0], 3'b000} ||
                    issued >= 8 || issued - popped >= 2) begin
                    nErr++;
                    $display("FAIL wb_read_issue: got addr %h w%b issued %0d outstanding %0d expected addr %h outstanding<2",
                             io_req_bits_addr, io_req_bits_write, issued, issued - popped,
                             {line, issued[2:0], 3'b000});
                end
                issued++;
            end
            if (wb_valid && wb_ready) begin
                nCmp++;
                if (wb_data !== refMem[{line, popped[2:0]}] || wb_last !== (popped == 7)) begin
                    nErr++;
                    $display("FAIL wb_beat %0d: got %h last %b expected %h last %b",
                             popped, wb_data, wb_last, refMem[{line, popped[2:0]}], popped == 7);
                end
                popped++;
            end else if (!wb_valid) begin
                nCmp++;
                if (wb_last !== 1'b0) begin
                    nErr++;
                    $display("FAIL wb_last_idle: got %b expected 0", wb_last);
                end
            end
            holdValid = wb_valid && !wb_ready;
            holdData = wb_data;
            @(posedge clk); #1;
        end
        wb_ready = 1'b0; refill_start = 1'b0;
        nCmp++;
        if (popped != 8 || issued != 8) begin
            nErr++;
            $display("FAIL wb_count: got popped %0d issued %0d expected 8 8", popped, issued);
        end
        @(negedge clk);
        nCmp++;
        if ({busy, wb_valid, refill_ready, cpu_req_ready} !== 4'b0001) begin
            nErr++;
            $display("FAIL wb_done: got %b expected 0001",
                     {busy, wb_valid, refill_ready, cpu_req_ready});
        end
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        if (both) begin
            repeat (3) begin
                @(negedge clk);
                nCmp++;
                if (refill_ready !== 1'b0 || busy !== 1'b0) begin
                    nErr++;
                    $display("FAIL dropped_refill: got ready %b busy %b expected 0 0",
                             refill_ready, busy);
                end
            end
        end
    endtask

    task automatic test_reset_mid_refill();
        @(posedge clk); #1;
        refill_start = 1'b1; refill_line_addr = 7'd9;
        @(posedge clk); #1;
        refill_start = 1'b0; refill_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            refill_data = {$urandom, $urandom};
            @(negedge clk);
            nCmp++;
            if (io_req_valid !== 1'b1 || io_req_bits_addr !== {7'd9, k[2:0], 3'b000}) begin
                nErr++;
                $display("FAIL partial_refill beat %0d: got v%b addr %h expected v1 addr %h",
                         k, io_req_valid, io_req_bits_addr, {7'd9, k[2:0], 3'b000});
            end
            refMem[{7'd9, k[2:0]}] = refill_data;
            @(posedge clk); #1;
        end
        reset = 1'b1; refill_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        nCmp++;
        if ({busy, refill_ready, io_req_valid, wb_valid, cpu_resp_valid, cpu_req_ready} !==
            6'b000001) begin
            nErr++;
            $display("FAIL reset_abort: got %b expected 000001",
                     {busy, refill_ready, io_req_valid, wb_valid, cpu_resp_valid, cpu_req_ready});
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            arrMem[i] = '0;
            refMem[i] = '0;
        end
        io_resp_0 = '0;
        cpu_req_valid = 0; cpu_req_write = 0; cpu_req_addr = '0;
        cpu_req_wdata = '0; cpu_req_wmask = '0;
        refill_start = 0; refill_valid = 0; refill_line_addr = '0; refill_data = '0;
        wb_start = 0; wb_ready = 0; wb_line_addr = '0;

        test_reset();
        test_cpu_basic();
        test_back_to_back();

        for (int k = 0; k < 8; k++) beats[k] = 64'(k) * 64'h0101010101010101;
        test_refill(7'd5, 1'b1);
        test_writeback(7'd5, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
        test_refill(7'd77, 1'b1);
        test_writeback(7'd77, 1'b1, 1'b0);
        test_writeback(7'd5, 1'b1, 1'b1);

        test_reset_mid_refill();
        for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
        test_refill(7'd9, 1'b0);
        test_writeback(7'd9, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
